// File: rtl/klotski_pkg.sv
// rtl/klotski_pkg.sv - shared types and grid index helpers for the Klotski move engine
package klotski_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, CHECK, MOVE, FINISH} state_t;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

  function automatic int cell_row(input int idx, input int cols);
    return idx / cols;
  endfunction

  function automatic int cell_col(input int idx, input int cols);
    return idx % cols;
  endfunction

  function automatic int cell_idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/klotski_move_check.sv
// rtl/klotski_move_check.sv - combinational legality, anchor and next-grid evaluation for one move
module klotski_move_check
  import klotski_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int COLS = 4,
  parameter int ID_W = 4,
  localparam int N  = ROWS * COLS,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0][ID_W-1:0] i_grid,
  input  logic [ID_W-1:0]        i_piece,
  input  dir_t                   i_dir,
  output logic                   o_legal,
  output logic [RW-1:0]          o_anchor_row,
  output logic [CW-1:0]          o_anchor_col,
  output logic [N-1:0][ID_W-1:0] o_next_grid
);

  int   dr, dc, nr, nc, sr, sc;
  logic found;

  always_comb begin
    dr = 0;
    dc = 0;
    nr = 0;
    nc = 0;
    sr = 0;
    sc = 0;
    case (i_dir)
      UP:      dr = -1;
      DOWN:    dr = 1;
      LEFT:    dc = -1;
      default: dc = 1;
    endcase
    found        = 1'b0;
    o_legal      = (i_piece != '0);
    o_anchor_row = '0;
    o_anchor_col = '0;
    o_next_grid  = i_grid;
    for (int i = 0; i < N; i++) begin
      nr = cell_row(i, COLS) + dr;
      nc = cell_col(i, COLS) + dc;
      sr = cell_row(i, COLS) - dr;
      sc = cell_col(i, COLS) - dc;
      if (i_grid[IW'(i)] == i_piece) begin
        if (!found) begin
          found        = 1'b1;
          o_anchor_row = RW'(cell_row(i, COLS));
          o_anchor_col = CW'(cell_col(i, COLS));
        end
        if (nr < 0 || nr >= ROWS || nc < 0 || nc >= COLS) begin
          o_legal = 1'b0;
        end else if (i_grid[IW'(cell_idx(nr, nc, COLS))] != i_piece &&
                     i_grid[IW'(cell_idx(nr, nc, COLS))] != '0) begin
          o_legal = 1'b0;
        end
      end
      // each cell pulls the piece from the cell behind it; vacated piece cells become empty
      if (sr >= 0 && sr < ROWS && sc >= 0 && sc < COLS &&
          i_grid[IW'(cell_idx(sr, sc, COLS))] == i_piece) begin
        o_next_grid[IW'(i)] = i_piece;
      end else if (i_grid[IW'(i)] == i_piece) begin
        o_next_grid[IW'(i)] = '0;
      end
    end
    o_legal = o_legal & found;
  end

endmodule

// File: rtl/klotski_move_engine.sv
// rtl/klotski_move_engine.sv - board-state engine: load, check, apply and issue Klotski moves
module klotski_move_engine
  import klotski_pkg::*;
#(
  parameter int ROWS     = 5,
  parameter int COLS     = 4,
  parameter int ID_W     = 4,
  parameter int GOAL_ID  = 1,
  parameter int GOAL_ROW = 3,
  parameter int GOAL_COL = 1,
  parameter int CNT_W    = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_load_valid,
  input  logic [ID_W-1:0]          i_load_id,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [ID_W-1:0]          i_cmd_piece,
  input  logic [1:0]               i_cmd_dir,
  output logic [$clog2(ROWS)-1:0]  o_pos_row,
  output logic [$clog2(COLS)-1:0]  o_pos_col,
  output logic [1:0]               o_direction,
  output logic                     o_en,
  input  logic                     i_ready,
  output logic                     o_err,
  output logic                     o_solved,
  output logic [CNT_W-1:0]         o_move_cnt
);

  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int IW = $clog2(N);

  typedef logic [N-1:0][ID_W-1:0] grid_t;

  state_t          state_q, state_d;
  grid_t           grid_q, grid_d, next_grid;
  logic [IW-1:0]   load_cnt_q, load_cnt_d;
  logic [ID_W-1:0] piece_q, piece_d;
  dir_t            dir_q, dir_d;
  logic [RW-1:0]   pos_row_q, pos_row_d, anchor_row;
  logic [CW-1:0]   pos_col_q, pos_col_d, anchor_col;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            solved_q, solved_d;
  logic            legal, start_load;

  function automatic logic goal_reached(input grid_t g);
    for (int i = 0; i < N; i++) begin
      if (g[IW'(i)] == ID_W'(GOAL_ID)) return (i == cell_idx(GOAL_ROW, GOAL_COL, COLS));
    end
    return 1'b0;
  endfunction

  klotski_move_check #(.ROWS(ROWS), .COLS(COLS), .ID_W(ID_W)) u_check (
    .i_grid       (grid_q),
    .i_piece      (piece_q),
    .i_dir        (dir_q),
    .o_legal      (legal),
    .o_anchor_row (anchor_row),
    .o_anchor_col (anchor_col),
    .o_next_grid  (next_grid)
  );

  always_comb begin
    state_d     = state_q;
    grid_d      = grid_q;
    load_cnt_d  = load_cnt_q;
    piece_d     = piece_q;
    dir_d       = dir_q;
    pos_row_d   = pos_row_q;
    pos_col_d   = pos_col_q;
    cnt_d       = cnt_q;
    solved_d    = solved_q;
    start_load  = 1'b0;
    o_cmd_ready = 1'b0;
    o_en        = 1'b0;
    o_err       = 1'b0;
    case (state_q)
      IDLE: start_load = i_start;
      LOAD: begin
        if (i_load_valid) begin
          grid_d[load_cnt_q] = i_load_id;
          load_cnt_d         = load_cnt_q + 1'b1;
          if (load_cnt_q == IW'(N - 1)) begin
            state_d  = WAIT;
            solved_d = goal_reached(grid_d);
          end
        end
      end
      WAIT: begin
        // a board that loads already solved skips straight to FINISH without taking commands
        if (i_start) begin
          start_load = 1'b1;
        end else if (solved_q) begin
          state_d = FINISH;
        end else begin
          o_cmd_ready = 1'b1;
          if (i_cmd_valid) begin
            piece_d = i_cmd_piece;
            dir_d   = dir_t'(i_cmd_dir);
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (legal) begin
          grid_d    = next_grid;
          pos_row_d = anchor_row;
          pos_col_d = anchor_col;
          solved_d  = goal_reached(next_grid);
          state_d   = MOVE;
        end else begin
          o_err   = 1'b1;
          state_d = WAIT;
        end
      end
      MOVE: begin
        o_en = 1'b1;
        if (i_ready) begin
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          state_d = solved_q ? FINISH : WAIT;
        end
      end
      FINISH:  start_load = i_start;
      default: state_d = IDLE;
    endcase
    if (start_load) begin
      state_d    = LOAD;
      load_cnt_d = '0;
      cnt_d      = '0;
      solved_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      grid_q     <= '0;
      load_cnt_q <= '0;
      piece_q    <= '0;
      dir_q      <= UP;
      pos_row_q  <= '0;
      pos_col_q  <= '0;
      cnt_q      <= '0;
      solved_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grid_q     <= grid_d;
      load_cnt_q <= load_cnt_d;
      piece_q    <= piece_d;
      dir_q      <= dir_d;
      pos_row_q  <= pos_row_d;
      pos_col_q  <= pos_col_d;
      cnt_q      <= cnt_d;
      solved_q   <= solved_d;
    end
  end

  assign o_pos_row   = pos_row_q;
  assign o_pos_col   = pos_col_q;
  assign o_direction = dir_q;
  assign o_solved    = solved_q;
  assign o_move_cnt  = cnt_q;

endmodule

// File: tb/tb_klotski_move_engine.sv
// tb/tb_klotski_move_engine.sv - directed self-checking bench for klotski_move_engine
module tb_klotski_move_engine;
  import klotski_pkg::*;

  typedef logic [3:0] board_t [20];

  logic       clk = 1'b0;
  logic       rst_n, i_start, i_load_valid, i_cmd_valid, i_ready;
  logic [3:0] i_load_id, i_cmd_piece;
  logic [1:0] i_cmd_dir;
  logic       o_cmd_ready, o_en, o_err, o_solved;
  logic [2:0] o_pos_row;
  logic [1:0] o_pos_col, o_direction, o_move_cnt;

  int n_cmp = 0;
  int n_err = 0;

  board_t std_b, std_mv, goal_b, goal_mv;

  always #5 clk = ~clk;

  klotski_move_engine #(.CNT_W(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_load_valid (i_load_valid),
    .i_load_id    (i_load_id),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_piece  (i_cmd_piece),
    .i_cmd_dir    (i_cmd_dir),
    .o_pos_row    (o_pos_row),
    .o_pos_col    (o_pos_col),
    .o_direction  (o_direction),
    .o_en         (o_en),
    .i_ready      (i_ready),
    .o_err        (o_err),
    .o_solved     (o_solved),
    .o_move_cnt   (o_move_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grid(input string tag, input board_t b);
    logic [19:0][3:0] e;
    for (int i = 0; i < 20; i++) e[i] = b[i];
    n_cmp++;
    assert (dut.grid_q === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, dut.grid_q, e);
    end
  endtask

  task automatic load_board(input board_t b);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("load_entry_solved", o_solved, 0);
    check("load_entry_cnt", o_move_cnt, 0);
    for (int i = 0; i < 20; i++) begin
      i_load_valid = 1'b1;
      i_load_id    = b[i];
      tick();
    end
    i_load_valid = 1'b0;
  endtask

  task automatic cmd_illegal(input string tag, input logic [3:0] piece, input logic [1:0] dir,
                             input board_t b, input logic [1:0] cnt);
    i_cmd_piece = piece;
    i_cmd_dir   = dir;
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    check({tag, "_err"}, o_err, 1);
    check({tag, "_en"}, o_en, 0);
    tick();
    check({tag, "_err_clr"}, o_err, 0);
    check({tag, "_ready"}, o_cmd_ready, 1);
    check({tag, "_cnt"}, o_move_cnt, cnt);
    check_grid({tag, "_grid"}, b);
  endtask

  task automatic move_ok(input string tag, input logic [3:0] piece, input logic [1:0] dir,
                         input logic [2:0] row, input logic [1:0] col, input logic [1:0] cnt);
    i_cmd_piece = piece;
    i_cmd_dir   = dir;
    check({tag, "_ready"}, o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    check({tag, "_noerr"}, o_err, 0);
    check({tag, "_en0"}, o_en, 0);
    tick();
    check({tag, "_en1"}, o_en, 1);
    check({tag, "_row"}, o_pos_row, row);
    check({tag, "_col"}, o_pos_col, col);
    check({tag, "_dir"}, o_direction, dir);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check({tag, "_en_done"}, o_en, 0);
    check({tag, "_cnt"}, o_move_cnt, cnt);
  endtask

  initial begin
    std_b   = '{4'd2, 4'd1, 4'd1, 4'd3,  4'd2, 4'd1, 4'd1, 4'd3,  4'd4, 4'd5, 4'd5, 4'd6,
                4'd4, 4'd7, 4'd8, 4'd6,  4'd9, 4'd0, 4'd0, 4'd10};
    std_mv  = '{4'd2, 4'd1, 4'd1, 4'd3,  4'd2, 4'd1, 4'd1, 4'd3,  4'd4, 4'd5, 4'd5, 4'd6,
                4'd4, 4'd0, 4'd8, 4'd6,  4'd9, 4'd7, 4'd0, 4'd10};
    goal_b  = '{4'd2, 4'd5, 4'd5, 4'd3,  4'd2, 4'd6, 4'd7, 4'd3,  4'd4, 4'd1, 4'd1, 4'd8,
                4'd4, 4'd1, 4'd1, 4'd8,  4'd9, 4'd0, 4'd0, 4'd10};
    goal_mv = '{4'd2, 4'd5, 4'd5, 4'd3,  4'd2, 4'd6, 4'd7, 4'd3,  4'd4, 4'd0, 4'd0, 4'd8,
                4'd4, 4'd1, 4'd1, 4'd8,  4'd9, 4'd1, 4'd1, 4'd10};
    rst_n = 1'b0; i_start = 1'b0; i_load_valid = 1'b0; i_load_id = '0;
    i_cmd_valid = 1'b0; i_cmd_piece = '0; i_cmd_dir = '0; i_ready = 1'b0;
    tick();
    tick();
    check("rst_ready", o_cmd_ready, 0);
    check("rst_en", o_en, 0);
    check("rst_err", o_err, 0);
    check("rst_solved", o_solved, 0);
    check("rst_cnt", o_move_cnt, 0);
    check("rst_row", o_pos_row, 0);
    check("rst_col", o_pos_col, 0);
    check("rst_dir", o_direction, 0);
    check("rst_state", dut.state_q, IDLE);
    rst_n = 1'b1;
    tick();

    load_board(std_b);
    check("std_ready", o_cmd_ready, 1);
    check("std_solved", o_solved, 0);
    check_grid("std_grid", std_b);
    cmd_illegal("p1_down", 4'd1, DOWN, std_b, 2'd0);

    i_cmd_piece = 4'd7;
    i_cmd_dir   = DOWN;
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    check("p7_check_en", o_en, 0);
    check("p7_check_err", o_err, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("p7_stall_en", o_en, 1);
      check("p7_stall_row", o_pos_row, 3);
      check("p7_stall_col", o_pos_col, 1);
      check("p7_stall_dir", o_direction, 1);
      check("p7_stall_cnt", o_move_cnt, 0);
      tick();
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("p7_done_en", o_en, 0);
    check("p7_done_cnt", o_move_cnt, 1);
    check_grid("p7_grid", std_mv);

    cmd_illegal("edge_up", 4'd2, UP, std_mv, 2'd1);
    cmd_illegal("piece0", 4'd0, UP, std_mv, 2'd1);
    cmd_illegal("absent", 4'd15, DOWN, std_mv, 2'd1);

    move_ok("sat1", 4'd7, UP,   3'd4, 2'd1, 2'd2);
    move_ok("sat2", 4'd7, DOWN, 3'd3, 2'd1, 2'd3);
    move_ok("sat3", 4'd7, UP,   3'd4, 2'd1, 2'd3);
    move_ok("sat4", 4'd7, DOWN, 3'd3, 2'd1, 2'd3);
    move_ok("sat5", 4'd7, UP,   3'd4, 2'd1, 2'd3);
    check_grid("sat_grid", std_b);

    load_board(goal_b);
    check("goal_pre_solved", o_solved, 0);
    move_ok("goal_mv", 4'd1, DOWN, 3'd2, 2'd1, 2'd1);
    check("goal_solved", o_solved, 1);
    check("goal_ready", o_cmd_ready, 0);
    check("goal_state", dut.state_q, FINISH);
    check_grid("goal_grid", goal_mv);
    i_cmd_piece = 4'd7;
    i_cmd_dir   = DOWN;
    i_cmd_valid = 1'b1;
    tick();
    tick();
    i_cmd_valid = 1'b0;
    check("fin_ignore_en", o_en, 0);
    check("fin_ignore_err", o_err, 0);
    check("fin_ignore_state", dut.state_q, FINISH);

    load_board(goal_mv);
    check("preload_solved", o_solved, 1);
    check("preload_ready", o_cmd_ready, 0);
    tick();
    check("preload_state", dut.state_q, FINISH);
    check("preload_cnt", o_move_cnt, 0);

    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_load_valid = 1'b1;
      i_load_id    = std_b[i];
      tick();
    end
    i_load_valid = 1'b1;
    i_load_id    = std_b[6];
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", o_cmd_ready, 0);
    check("mid_rst_en", o_en, 0);
    check("mid_rst_err", o_err, 0);
    check("mid_rst_solved", o_solved, 0);
    check("mid_rst_cnt", o_move_cnt, 0);
    check("mid_rst_row", o_pos_row, 0);
    check("mid_rst_col", o_pos_col, 0);
    check("mid_rst_dir", o_direction, 0);
    check("mid_rst_state", dut.state_q, IDLE);
    i_load_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    load_board(std_b);
    check_grid("reload_grid", std_b);
    move_ok("reload_mv", 4'd7, DOWN, 3'd3, 2'd1, 2'd1);
    check_grid("reload_mv_grid", std_mv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
